instr_decode_reg: RTL and testbench
===================================

// Module: instr_decode_reg
// PURPOSE
//   Pipeline register between instruction fetch and execute of the 18-bit core.
//   Captures each fetched 18-bit instruction word, splits it into opcode, register and
//   6-bit immediate fields, and holds them stable for execute.
//   The imm6 field feeds the 6-to-18 sign extender directly.
//   Implemented as a 2-entry skid buffer: full throughput, and every handshake signal
//   is driven from a register.
// PARAMETERS
//   IW    18  instruction word width
//   OPW    4  opcode width, bits [IW-1 -: OPW]
//   RW     4  register-index width (rd, rs1, rs2)
//   IMMW   6  immediate width, bits [IMMW-1:0]
// PORTS
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous active-high reset
//   flush      in   1     synchronous; discard all held instructions (branch taken)
//   in_valid   in   1     fetch presents in_instr
//   in_ready   out  1     this block can accept; registered
//   in_instr   in   IW    instruction word
//   out_valid  out  1     decoded fields valid; registered
//   out_ready  in   1     execute consumes this cycle
//   out_instr  out  IW    raw word of the head entry
//   opcode     out  OPW   out_instr[17:14]
//   rd         out  RW    out_instr[13:10]
//   rs1        out  RW    out_instr[9:6]
//   rs2        out  RW    out_instr[3:0]
//   imm6       out  IMMW  out_instr[5:0]; to the sign extender, unextended
// BEHAVIOUR
//   - Storage: main reg (M, drives outputs) and skid reg (S); valid bits mv and sv.
//   - Handshakes:
//     - accept = in_valid & in_ready; pop = out_valid & out_ready.
//     - in_ready = ~sv. out_valid = mv.
//   - Field outputs are pure slices of M; they change only when M loads.
//   - States: EMPTY (mv=0,sv=0), ONE (mv=1,sv=0), FULL (mv=1,sv=1). Per cycle:
//     - EMPTY: accept -> M<=in, ONE.
//     - ONE, pop & accept: M<=in, stay ONE.
//     - ONE, pop & ~accept: EMPTY.
//     - ONE, ~pop & accept: S<=in, FULL.
//     - FULL: accept is impossible (in_ready=0).
//     - FULL, pop: M<=S, sv<=0, ONE.
//   - Latency: accepted word is visible on outputs the cycle after acceptance. A
//     consumer holding out_ready=1 sees one instruction per cycle.
//   - Ordering: strictly FIFO. Nothing is dropped or duplicated except by flush.
//   - flush=1 at a clock edge:
//     - Clears mv and sv; in_ready=1 next cycle.
//     - An accept or pop in that same cycle is discarded.
//     - flush has priority over all other events.
//   - Data regs (M, S) are not cleared by flush; consumers must qualify with out_valid.
//   - Reset (async, immediate on rst rise):
//     - mv=sv=0, so out_valid=0 and in_ready=1.
//     - M=S=0, so opcode/rd/rs1/rs2/imm6 = 0.
//     - Reset mid-transfer drops all held words; the first accept after rst falls
//       loads M.
//   - Output stability: while out_valid=1 & out_ready=0, M and all field outputs
//     hold unchanged.
//   - No combinational path exists from out_ready or in_valid to any output.
// TESTING
//   1. Reset: drive rst=1 with in_valid=1 -> out_valid=0, in_ready=1, imm6=0
//      throughout.
//   2. Stream 0x3_FFFF, 0x0_0015, 0x2_A83F with out_ready=1 -> each appears one cycle
//      after accept. For 0x2_A83F: opcode=0xA, rd=0xA, rs1=0x0, imm6=0x3F.
//   3. Backpressure: out_ready=0, offer A,B,C -> in_ready drops after B, C held
//      upstream, outputs stay A. Release -> A,B,C in order, no gaps.
//   4. Flush while FULL: same cycle pop=1 and flush=1 -> next cycle out_valid=0,
//      in_ready=1, and neither held word ever reappears.
//   5. Async reset in FULL mid-cycle -> out_valid falls before the next clk edge.
//      Next accepted word 0x1_2345 emerges alone.
//   6. Random valid/ready for 10k cycles against a reference queue -> order/content
//      match, in_ready==~sv always, fields==slices of out_instr.

Source files
------------

// File: rtl/instr_decode_reg.sv
// ---------------------------------------------------------------------------
// instr_decode_reg
//   Pipeline register between instruction fetch and execute of the 18-bit
//   core. This is a 2-entry skid buffer. The main entry drives the outputs.
//   The skid entry catches the one word that fetch may still present in the
//   cycle in which execute stalls. The block runs at full throughput. Both
//   handshake outputs are taken straight from state-register bits.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (clears valid bits and data)
//   i_flush      synchronous discard of every held instruction
//   i_in_valid   fetch presents i_in_instr
//   o_in_ready   block can accept this cycle (registered)
//   i_in_instr   instruction word from fetch
//   o_out_valid  decoded fields valid (registered)
//   i_out_ready  execute consumes the head entry this cycle
//   o_out_instr  raw word of the head entry
//   o_opcode     head[17:14]
//   o_rd         head[13:10]
//   o_rs1        head[9:6]
//   o_rs2        head[3:0]
//   o_imm6       head[5:0], unextended (feeds the sign extender)
// ---------------------------------------------------------------------------
module instr_decode_reg #(
  parameter int IW   = 18,
  parameter int OPW  = 4,
  parameter int RW   = 4,
  parameter int IMMW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [IW-1:0]   i_in_instr,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [IW-1:0]   o_out_instr,
  output logic [OPW-1:0]  o_opcode,
  output logic [RW-1:0]   o_rd,
  output logic [RW-1:0]   o_rs1,
  output logic [RW-1:0]   o_rs2,
  output logic [IMMW-1:0] o_imm6
);

  // The state encoding is chosen so that bit 1 is the main-valid flag and
  // bit 0 is the skid-valid flag. Both handshake outputs are therefore
  // plain flop outputs with no decode logic.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [IW-1:0] r_main;
  logic [IW-1:0] r_skid;

  logic          w_accept;
  logic          w_pop;
  logic          w_load_main;
  logic          w_main_from_skid;
  logic          w_load_skid;
  logic [IW-1:0] w_main_d;

  assign w_accept = i_in_valid & ~r_state[0];
  assign w_pop    = r_state[1] & i_out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_load_main  = 1'b1;
          w_state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_pop && w_accept) begin
          w_load_main = 1'b1;
        end else if (w_pop) begin
          w_state_next = ST_EMPTY;
        end else if (w_accept) begin
          w_load_skid  = 1'b1;
          w_state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain of the skid entry matters.
        if (w_pop) begin
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
          w_state_next     = ST_ONE;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase
    // Flush overrides everything. Same-cycle loads are also suppressed, so
    // the data registers keep their old contents and only the valid bits
    // drop.
    if (i_flush) begin
      w_state_next     = ST_EMPTY;
      w_load_main      = 1'b0;
      w_main_from_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  assign w_main_d = w_main_from_skid ? r_skid : i_in_instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main) r_main <= w_main_d;
      if (w_load_skid) r_skid <= i_in_instr;
    end
  end

  assign o_out_valid = r_state[1];
  assign o_in_ready  = ~r_state[0];
  assign o_out_instr = r_main;
  assign o_opcode    = r_main[IW-1 -: OPW];
  assign o_rd        = r_main[IW-OPW-1 -: RW];
  assign o_rs1       = r_main[IW-OPW-RW-1 -: RW];
  assign o_rs2       = r_main[RW-1:0];
  assign o_imm6      = r_main[IMMW-1:0];

endmodule

// File: tb/tb_instr_decode_reg.sv
// ---------------------------------------------------------------------------
// tb_instr_decode_reg
//   Self-checking bench for instr_decode_reg. A reference model keeps a queue
//   that holds at most two words. A compare process checks the DUT against
//   that queue on every falling edge. Directed sequences add literal
//   expectations. A long randomized run follows them.
// ---------------------------------------------------------------------------
module tb_instr_decode_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_instr;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [5:0]  imm6;

  int checks   = 0;
  int failures = 0;

  logic [17:0] q[$];

  always #5 clk = ~clk;

  instr_decode_reg dut (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_instr  (in_instr),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_instr (out_instr),
    .o_opcode    (opcode),
    .o_rd        (rd),
    .o_rs1       (rs1),
    .o_rs2       (rs2),
    .o_imm6      (imm6)
  );

  // Reference model: the buffer is a queue holding at most two words.
  // Acceptance is decided by the occupancy before the edge.
  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (in_valid) q.push_back(in_instr);
    end else if (q.size() == 1) begin
      if (out_ready) void'(q.pop_front());
      if (in_valid) q.push_back(in_instr);
    end else begin
      if (out_ready) void'(q.pop_front());
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic compare_loop();
    logic [17:0] w;
    forever begin
      @(negedge clk);
      chk("model_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("model_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      if (q.size() > 0) begin
        w = q[0];
        chk("model_out_instr", {14'd0, out_instr}, {14'd0, w});
        chk("model_opcode", {28'd0, opcode}, 32'(w / 18'd16384));
        chk("model_rd", {28'd0, rd}, 32'((w / 18'd1024) % 18'd16));
        chk("model_rs1", {28'd0, rs1}, 32'((w / 18'd64) % 18'd16));
        chk("model_rs2", {28'd0, rs2}, 32'(w % 18'd16));
        chk("model_imm6", {26'd0, imm6}, 32'(w % 18'd64));
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [17:0] stream [3];
    stream[0] = 18'h3FFFF;
    stream[1] = 18'h00015;
    stream[2] = 18'h2A83F;

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 18'h3FFFF;
    out_ready = 1'b0;

    fork
      compare_loop();
    join_none

    // Reset held with fetch offering a word: nothing may be captured.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_imm6", {26'd0, imm6}, 32'd0);
      chk("rst_out_instr", {14'd0, out_instr}, 32'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    cyc();

    // Streaming with execute always ready: one word per cycle, one cycle of latency.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = stream[i];
      cyc();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_word", {14'd0, out_instr}, {14'd0, stream[i]});
      if (i == 2) begin
        chk("lit_opcode", {28'd0, opcode}, 32'hA);
        chk("lit_rd", {28'd0, rd}, 32'hA);
        chk("lit_rs1", {28'd0, rs1}, 32'h0);
        chk("lit_imm6", {26'd0, imm6}, 32'h3F);
      end
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_drain", {31'd0, out_valid}, 32'd0);

    // Backpressure: A and B are taken in, C waits upstream, and the outputs hold A.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 18'h0ABCD;
    cyc();
    chk("bp_ready_after_a", {31'd0, in_ready}, 32'd1);
    in_instr = 18'h1BEEF;
    cyc();
    chk("bp_ready_after_b", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_a", {14'd0, out_instr}, 32'h0ABCD);
    in_instr = 18'h2C0DE;
    cyc();
    cyc();
    chk("bp_still_a", {14'd0, out_instr}, 32'h0ABCD);
    chk("bp_c_blocked", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    cyc();
    chk("bp_out_b", {14'd0, out_instr}, 32'h1BEEF);
    cyc();
    chk("bp_out_c", {14'd0, out_instr}, 32'h2C0DE);
    chk("bp_out_c_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    cyc();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush while FULL, with a pop in the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 18'h11111;
    cyc();
    in_instr = 18'h22222;
    cyc();
    in_instr  = 18'h33333;
    out_ready = 1'b1;
    flush     = 1'b1;
    cyc();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("flush_no_reappear", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b1;
    in_instr = 18'h0F0F0;
    cyc();
    chk("flush_next_word", {14'd0, out_instr}, 32'h0F0F0);
    in_valid = 1'b0;
    cyc();
    chk("flush_next_alone", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset while FULL, between clock edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 18'h3AAAA;
    cyc();
    in_instr = 18'h05555;
    cyc();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst_instr", {14'd0, out_instr}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 18'h12345;
    cyc();
    chk("post_rst_word", {14'd0, out_instr}, 32'h12345);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    cyc();
    chk("post_rst_alone", {31'd0, out_valid}, 32'd0);

    // Randomized traffic. Every cycle is checked by the compare process.
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) >= ((n / 1000) % 3));
      flush     = ($urandom_range(0, 63) == 0);
      in_instr  = 18'($urandom());
      cyc();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
